// File: rtl/life_pkg.sv
// life_pkg: shared FSM state type, default geometry/width parameters and the
// grid cell-index helper for the Game of Life generation controller.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned LIFE_N      = 8;
    localparam int unsigned LIFE_RATE_W = 8;
    localparam int unsigned LIFE_GEN_W  = 16;

    // Flat bit position of cell (r,c) in an n-by-n grid vector.
    function automatic int unsigned cell_idx(input int unsigned r,
                                             input int unsigned c,
                                             input int unsigned n);
        return r * n + c;
    endfunction

endpackage

// File: rtl/life_tick.sv
// life_tick: loadable down-counter that paces generations in free-run mode.
// zero is high whenever the count has reached 0 (a "tick" cycle).
module life_tick
    import life_pkg::*;
#(
    parameter int unsigned W = LIFE_RATE_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    // Reload on request, otherwise count down while enabled and stop at zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/life_ctrl.sv
// life_ctrl: Game of Life generation controller. Holds the current grid,
// loads seeds, and commits the datapath's next generation in single-step,
// free-run or run-to-limit mode.
// Optional build macro: LIFE_STILL_DETECT_EN -- stops a run on a still life
// and reports it on the extra 'still' output.
module life_ctrl
    import life_pkg::*;
#(
    parameter int unsigned N      = LIFE_N,
    parameter int unsigned RATE_W = LIFE_RATE_W,
    parameter int unsigned GEN_W  = LIFE_GEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              seed_load,
    input  logic [N*N-1:0]    seed,
    input  logic              start,
    input  logic              step,
    input  logic              stop,
    input  logic [RATE_W-1:0] rate,
    input  logic [GEN_W-1:0]  gen_limit,
    input  logic [N*N-1:0]    grid_next,
    output logic [N*N-1:0]    grid,
    output logic              grid_evolve,
    output logic [GEN_W-1:0]  gen_count,
    output logic              busy,
    output logic              done
`ifdef LIFE_STILL_DETECT_EN
    ,
    output logic              still
`endif
);

    state_t             state_q;
    logic [N*N-1:0]     grid_q;
    logic [GEN_W-1:0]   gen_q;
    logic [GEN_W-1:0]   gen_inc_d;
    logic               evolve_q;
    logic               busy_q;
    logic               done_q;
    logic               limit_hit;
    logic               tick_load;
    logic               tick_en;
    logic               tick_zero;
`ifdef LIFE_STILL_DETECT_EN
    logic               still_q;
`endif

    // Saturating next count, limit detection and delay-counter control.
    always_comb begin
        if (gen_q != {GEN_W{1'b1}}) begin
            gen_inc_d = gen_q + GEN_W'(1);
        end else begin
            gen_inc_d = gen_q;
        end
        limit_hit = (gen_limit != '0) && (gen_inc_d == gen_limit);
        tick_en   = (state_q == RUN);
        if (state_q == IDLE) begin
            tick_load = !seed_load && !step && start;
        end else if (state_q == RUN) begin
            tick_load = tick_zero && !stop;
        end else begin
            tick_load = 1'b0;
        end
    end

    life_tick #(.W(RATE_W)) u_tick (
        .clk      (clk),
        .reset    (reset),
        .load     (tick_load),
        .load_val (rate),
        .en       (tick_en),
        .zero     (tick_zero)
    );

    // Generation FSM; grid, count and status flags all update on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            grid_q   <= '0;
            gen_q    <= '0;
            evolve_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef LIFE_STILL_DETECT_EN
            still_q  <= 1'b0;
`endif
        end else begin
            evolve_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (seed_load) begin
                        grid_q <= seed;
                        gen_q  <= '0;
                    end else if (step) begin
                        state_q <= STEP;
                        busy_q  <= 1'b1;
                    end else if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                STEP: begin
                    grid_q   <= grid_next;
                    gen_q    <= gen_inc_d;
                    evolve_q <= 1'b1;
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                end
                RUN: begin
                    if (stop) begin
                        // Abort wins over a coincident tick: nothing commits.
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
`ifdef LIFE_STILL_DETECT_EN
                    end else if (tick_zero && (grid_next == grid_q)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        still_q <= 1'b1;
`endif
                    end else if (tick_zero) begin
                        grid_q   <= grid_next;
                        gen_q    <= gen_inc_d;
                        evolve_q <= 1'b1;
                        if (limit_hit) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (seed_load) begin
                        grid_q  <= seed;
                        gen_q   <= '0;
                        state_q <= IDLE;
                        done_q  <= 1'b0;
`ifdef LIFE_STILL_DETECT_EN
                        still_q <= 1'b0;
`endif
                    end else if (stop) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
`ifdef LIFE_STILL_DETECT_EN
                        still_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign grid        = grid_q;
    assign grid_evolve = evolve_q;
    assign gen_count   = gen_q;
    assign busy        = busy_q;
    assign done        = done_q;
`ifdef LIFE_STILL_DETECT_EN
    assign still       = still_q;
`endif

endmodule

// File: doc/life_ctrl.md
# life_ctrl

Generation controller for the Game of Life datapath. It owns the current-generation grid register, loads a seed pattern, and commits the datapath's combinational next-generation grid at a programmable rate. Supported modes are single-step, free-run and run-to-limit. It sits between the top-level user/test controls and the `datapath` evolve logic, and pulses `grid_evolve` on every committed generation.

## Interface
Parameters:
- `N`, 8: grid edge length; grid vectors are N*N bits, cell (r,c) at bit r*N+c.
- `RATE_W`, 8: width of the inter-generation delay field.
- `GEN_W`, 16: width of the generation counter and limit.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `seed_load`  in  1  load `seed` into grid (IDLE/DONE only).
- `seed`  in  N*N  seed pattern.
- `start`  in  1  enter free-run.
- `step`  in  1  advance exactly one generation.
- `stop`  in  1  abort run, return to IDLE.
- `rate`  in  RATE_W  idle cycles between generations in RUN; 0 = every cycle.
- `gen_limit`  in  GEN_W  stop after this many generations in RUN; 0 = unlimited.
- `grid_next`  in  N*N  next generation from datapath (combinational from `grid`).
- `grid`  out  N*N  current generation register.
- `grid_evolve`  out  1  one-cycle pulse, high in the cycle `grid` shows a newly committed generation.
- `gen_count`  out  GEN_W  generations committed since last seed load.
- `busy`  out  1  high in RUN or STEP.
- `done`  out  1  high in DONE.

## Operation
- Reset (`reset`==0 at edge): state IDLE; `grid`=0, `gen_count`=0, `grid_evolve`=0, `busy`=0, `done`=0, delay counter=0.
- States: IDLE, RUN, STEP, DONE.
- IDLE, one-hot priority `seed_load` > `step` > `start`:
  - `seed_load`: `grid`<=`seed`, `gen_count`<=0, stay IDLE.
  - `step`: go to STEP.
  - `start`: go to RUN; delay counter<=`rate`.
- STEP, one cycle: `grid`<=`grid_next`, `gen_count`+1, `grid_evolve` pulse, then IDLE.
- RUN:
  - A tick is a cycle with counter==0; otherwise the counter decrements.
  - On a tick: commit `grid_next`, increment `gen_count`, reload counter with `rate`.
  - `stop` has priority over a tick: no commit, go to IDLE.
  - After a commit, if `gen_limit`!=0 and the new `gen_count`==`gen_limit`: go to DONE.
  - `seed_load`, `step` and `start` are ignored in RUN.
- DONE: `grid` holds.
  - `seed_load`: load seed as in IDLE, then IDLE.
  - `stop`: IDLE.
  - `start` and `step` are ignored.
- `gen_count` saturates at 2^GEN_W-1; `grid` keeps updating after saturation.
- `rate` and `gen_limit` are sampled live. A `rate` change takes effect at the next reload.

## Timing
- Synchronous single-clock design. `grid`, `gen_count` and `grid_evolve` are registered together.
- `step` sampled at edge t: commit at edge t+1. `grid_evolve`=1 during cycle t+1..t+2.
- `start` sampled at edge t: first commit at edge t+1+`rate`, then every `rate`+1 cycles.
- `gen_limit`=L from seed: `done`=1 starting the edge of the L-th commit. `busy` drops at the same edge.
- Reset mid-RUN: next edge gives full reset values. No partial commit.
- `grid_next` must settle within one cycle; the controller adds no pipeline stage.

## Configuration
- `LIFE_STILL_DETECT_EN` defined:
  - On a RUN tick, if `grid_next`==`grid`, go to DONE without commit, without `gen_count` increment and without `grid_evolve`.
  - An extra output `still` (1 bit) is high in DONE when entered this way. It is cleared on leaving DONE and is 0 at reset.
  - STEP is unaffected.
- `LIFE_STILL_DETECT_EN` undefined: no compare logic and no `still` port. Still lifes run until `stop` or the limit.

## Structure
- `life_pkg`: `state_t` enum (IDLE, RUN, STEP, DONE), default `N`/`RATE_W`/`GEN_W` localparams, and a cell-index function r*N+c.
- Sub-module `life_tick`: loadable down-counter of width RATE_W with `load`, `en` and `zero` outputs, used for the RUN delay.
- The FSM, grid register and counter stay in `life_ctrl`. The evolve logic stays in `datapath`.

## Test plan
- N=5 blinker seed (cells (2,1),(2,2),(2,3)), `step` ×2 -> vertical then horizontal blinker; `gen_count`=2; two `grid_evolve` pulses.
- Glider seed, `rate`=3, `gen_limit`=4, `start` -> commits 4 cycles apart; `done`=1 after 4th commit; `gen_count`=4; `busy`=0.
- 2×2 block seed, `start`, `gen_limit`=0:
  - with `LIFE_STILL_DETECT_EN` -> DONE on the first tick, `still`=1, `gen_count`=0;
  - without it -> `gen_count` increments until `stop`.
- RUN with `rate`=0, `stop` asserted in the same cycle as a tick -> no commit, IDLE next edge, `gen_count` unchanged.
- `reset`=0 for one edge mid-RUN -> `grid`=0, `gen_count`=0, state IDLE; `seed_load`+`step`+`start` together in IDLE -> only the seed loads.
- `GEN_W`=4, `gen_limit`=0, `rate`=0, run 20 cycles -> `gen_count` saturates at 15 while `grid_evolve` keeps pulsing.
